// File: rtl/conv2_k_mem_write.sv
// Streams the six conv2 5x5 weight kernels into the weight RAM write port.
// Optional running sum of accepted words: define CONV2_K_WR_CHECKSUM_EN.
module conv2_k_mem_write #(
   parameter int DATA_W = 16,
   parameter int KSIZE  = 25,
   parameter int NKERN  = 6,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done
`ifdef CONV2_K_WR_CHECKSUM_EN
   ,
   output logic [DATA_W+7:0] checksum
`endif
);

   localparam int TAP_W  = (KSIZE > 1) ? $clog2(KSIZE) : 1;
   localparam int KERN_W = (NKERN > 1) ? $clog2(NKERN) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [TAP_W-1:0]    r_tap;
   logic [KERN_W-1:0]   r_kernel;
   logic [ADDR_W-1:0]   r_offset;
   logic                r_inReady;
   logic                r_we;
   logic [ADDR_W-1:0]   r_waddr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_busy;
   logic                r_done;
`ifdef CONV2_K_WR_CHECKSUM_EN
   logic [DATA_W+7:0]   r_checksum;
`endif

   logic w_accept;
   logic w_tapLast;
   logic w_lastBeat;

   assign w_accept   = in_valid && r_inReady;
   assign w_tapLast  = (r_tap == TAP_W'(KSIZE - 1));
   assign w_lastBeat = w_tapLast && (r_kernel == KERN_W'(NKERN - 1));

   // The kernel base offset advances by KSIZE on each tap wrap, so the
   // address is offset + tap with no multiplier.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_tap      <= '0;
         r_kernel   <= '0;
         r_offset   <= '0;
         r_inReady  <= 1'b0;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef CONV2_K_WR_CHECKSUM_EN
         r_checksum <= '0;
`endif
      end else begin
         r_we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state    <= S_LOAD;
                  r_tap      <= '0;
                  r_kernel   <= '0;
                  r_offset   <= '0;
                  r_inReady  <= 1'b1;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
`ifdef CONV2_K_WR_CHECKSUM_EN
                  r_checksum <= '0;
`endif
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_we    <= 1'b1;
                  r_waddr <= r_offset + ADDR_W'(r_tap);
                  r_wdata <= in_data;
`ifdef CONV2_K_WR_CHECKSUM_EN
                  r_checksum <= r_checksum + (DATA_W+8)'(in_data);
`endif
                  if (w_lastBeat) begin
                     r_state   <= S_FLUSH;
                     r_inReady <= 1'b0;
                     r_tap     <= '0;
                     r_kernel  <= '0;
                     r_offset  <= '0;
                  end else if (w_tapLast) begin
                     r_tap    <= '0;
                     r_kernel <= r_kernel + 1'b1;
                     r_offset <= r_offset + ADDR_W'(KSIZE);
                  end else begin
                     r_tap <= r_tap + 1'b1;
                  end
               end
            end
            S_FLUSH: begin
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready = r_inReady;
   assign we       = r_we;
   assign waddr    = r_waddr;
   assign wdata    = r_wdata;
   assign busy     = r_busy;
   assign done     = r_done;
`ifdef CONV2_K_WR_CHECKSUM_EN
   assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_conv2_k_mem_write.sv
// Directed bench for conv2_k_mem_write: full-rate, gapped, mid-load start,
// mid-load reset and (with CONV2_K_WR_CHECKSUM_EN) checksum loads.
module tb_conv2_k_mem_write;

   logic        clk;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        we;
   logic [7:0]  waddr;
   logic [15:0] wdata;
   logic        busy;
   logic        done;
`ifdef CONV2_K_WR_CHECKSUM_EN
   logic [23:0] checksum;
`endif

   int          errorCount = 0;
   int          checkCount = 0;
   int          expIdx     = 0;
   logic        expLoad    = 1'b0;
   logic [23:0] expSum     = '0;

   conv2_k_mem_write dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done)
`ifdef CONV2_K_WR_CHECKSUM_EN
      ,
      .checksum (checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle of stimulus; the model predicts acceptance from its own
   // view of the load state and checks the write one cycle later.
   task automatic applyStimulus(input logic v, input logic [15:0] d, input logic st);
      logic acc;
      in_valid = v;
      in_data  = d;
      start    = st;
      acc      = expLoad && v;
      tick();
      start    = 1'b0;
      checkOutput("we", 32'(we), 32'(acc));
      if (acc) begin
         checkOutput("waddr", 32'(waddr), 32'(expIdx));
         checkOutput("wdata", 32'(wdata), 32'(d));
         expSum = expSum + 24'(d);
         expIdx++;
         if (expIdx == 150) expLoad = 1'b0;
      end
      checkOutput("in_ready", 32'(in_ready), 32'(expLoad));
   endtask

   task automatic doStart(input string tag);
      in_valid = 1'b0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      expLoad  = 1'b1;
      expIdx   = 0;
      expSum   = '0;
      checkOutput({tag, "_we"}, 32'(we), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
`ifdef CONV2_K_WR_CHECKSUM_EN
      checkOutput({tag, "_checksum"}, 32'(checksum), 32'd0);
`endif
   endtask

   // Called in the FLUSH cycle, right after the last write was sampled.
   task automatic finishLoad(input string tag);
      checkOutput({tag, "_flushBusy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_flushDone"}, 32'(done), 32'd0);
      applyStimulus(1'b1, 16'hDEAD, 1'b0);
      checkOutput({tag, "_done"}, 32'(done), 32'd1);
      checkOutput({tag, "_busyLow"}, 32'(busy), 32'd0);
      applyStimulus(1'b1, 16'hBEEF, 1'b0);
      checkOutput({tag, "_doneHeld"}, 32'(done), 32'd1);
`ifdef CONV2_K_WR_CHECKSUM_EN
      checkOutput({tag, "_checksum"}, 32'(checksum), 32'(expSum));
`endif
   endtask

   initial begin
      int i;
      int cycles;
      logic v;
      logic midStartDone;

      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      tick();
      tick();
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_we", 32'(we), 32'd0);
      checkOutput("rst_waddr", 32'(waddr), 32'd0);
      checkOutput("rst_wdata", 32'(wdata), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
`ifdef CONV2_K_WR_CHECKSUM_EN
      checkOutput("rst_checksum", 32'(checksum), 32'd0);
`endif
      reset = 1'b1;

      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 16'h5555, 1'b0);
      checkOutput("idle_busy", 32'(busy), 32'd0);

      $display("[TB] full-rate load");
      doStart("full");
      for (int k = 0; k < 150; k++) begin
         applyStimulus(1'b1, 16'(16'h1000 + k), 1'b0);
         if (k == 75) checkOutput("kernelAt75", 32'(dut.r_kernel), 32'd3);
      end
      finishLoad("full");

      $display("[TB] gapped load with mid-load start");
      doStart("gap");
      i = 0;
      cycles = 0;
      midStartDone = 1'b0;
      while (i < 150 && cycles < 2000) begin
         v = 1'($urandom_range(0, 1));
         if (i == 40 && !midStartDone) begin
            applyStimulus(1'b1, 16'(16'h1000 + i), 1'b1);
            midStartDone = 1'b1;
            i++;
         end else begin
            applyStimulus(v, 16'(16'h1000 + i), 1'b0);
            if (v) i++;
         end
         cycles++;
      end
      checkOutput("gapCount", 32'(i), 32'd150);
      finishLoad("gap");

      $display("[TB] reset after 60 words");
      doStart("rst");
      for (int k = 0; k < 60; k++) applyStimulus(1'b1, 16'(16'h2000 + k), 1'b0);
      reset    = 1'b0;
      in_valid = 1'b1;
      tick();
      expLoad  = 1'b0;
      checkOutput("midRst_we", 32'(we), 32'd0);
      checkOutput("midRst_busy", 32'(busy), 32'd0);
      checkOutput("midRst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("midRst_done", 32'(done), 32'd0);
      reset = 1'b1;
      applyStimulus(1'b1, 16'h1234, 1'b0);

      $display("[TB] reload with all-ones words");
      doStart("ones");
      for (int k = 0; k < 150; k++) applyStimulus(1'b1, 16'hFFFF, 1'b0);
      finishLoad("ones");
`ifdef CONV2_K_WR_CHECKSUM_EN
      checkOutput("onesChecksumConst", 32'(checksum), 32'h0095FF6A);
`endif
      doStart("restart");

      $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/conv2_k_mem_write.md
# conv2_k_mem_write

Loads the six 5×5 Convolution 2 weight kernels (150 words) from a valid/ready input stream into the conv2 weight memory, generating write strobe, address and data. It is the write-side counterpart of the conv2 weight-memory read counter. Kernels 0–2 occupy addresses 0–74 and kernels 3–5 occupy addresses 75–149, so the read side's two ports (base 0 and base 75, kernel offsets 0/25/50) find them in place. The block sits between the host weight-download path and the weight RAM write port, and runs once per network load, before conv2 is enabled.

## Interface
- DATA_W, 16, weight word width
- KSIZE, 25, taps per kernel (5×5)
- NKERN, 6, kernels stored
- ADDR_W, 8, memory address width; must satisfy KSIZE*NKERN ≤ 2^ADDR_W

- clk  in  1  rising-edge clock
- reset  in  1  one clock; reset is synchronous and active-low (reset==0 on a clk edge resets the block)
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE
- in_valid  in  1  input word valid
- in_data  in  DATA_W  weight word; stream order is kernel-major, tap-minor (k0t0..k0t24, k1t0..k5t24)
- in_ready  out  1  block accepts in_data this cycle
- we  out  1  memory write strobe
- waddr  out  ADDR_W  write address
- wdata  out  DATA_W  write data
- busy  out  1  high in LOAD and FLUSH
- done  out  1  high in DONE; all 150 words have been written
- checksum  out  DATA_W+8  present only with CONV2_K_WR_CHECKSUM_EN

## Operation
- Internal state: tap counter (0..KSIZE-1), kernel counter (0..NKERN-1), and offset register = kernel*KSIZE. The offset is maintained by adding KSIZE; no multiplier is used.
- FSM states and transitions:
  - IDLE → LOAD on start.
  - LOAD → FLUSH after the beat with kernel==NKERN-1 and tap==KSIZE-1 is accepted.
  - FLUSH → DONE after one cycle.
  - DONE → LOAD on start.
- On entry to LOAD, tap, kernel and offset clear to 0.
- in_ready = 1 only in LOAD. A beat is accepted when in_valid && in_ready.
- On an accepted beat:
  - Next cycle: we=1, waddr = offset + tap, wdata = in_data.
  - Tap increments. At tap==KSIZE-1, tap wraps to 0, kernel increments and offset += KSIZE.
- Cycles with no accepted beat produce we=0 on the following cycle. waddr and wdata hold their last values.
- Address arithmetic is unsigned in ADDR_W bits. The maximum address is 149 (0x95).
- in_valid outside LOAD is ignored: no write, no counter change.
- start in LOAD or FLUSH is ignored.
- Reset mid-load (reset==0 on any edge) returns to IDLE at that edge. Counters clear, we drops the same edge, and the partially written memory contents are not cleared.
- Reset values: in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, checksum=0; state IDLE.

## Timing
- Write latency: exactly 1 cycle from acceptance to we/waddr/wdata.
- Full rate: one word per cycle with in_valid held high. 150 accept cycles, then the last write appears during FLUSH.
- done rises 2 cycles after the final acceptance and stays high until start or reset.
- in_ready drops in the cycle after the final acceptance; the FLUSH cycle shows in_ready=0.
- busy is high from the cycle after start through FLUSH.
- Restart from DONE: done falls and busy rises on the edge after start. No stale write is issued.

## Configuration
- CONV2_K_WR_CHECKSUM_EN defined:
  - checksum port exists.
  - Cleared to 0 on start. Adds the zero-extended in_data for every accepted beat, modulo 2^(DATA_W+8).
  - Final value is stable while done=1.
- CONV2_K_WR_CHECKSUM_EN undefined:
  - Port and accumulator are absent.
  - All other behaviour is identical.

## Test plan
- Full-rate load, in_data = 0x1000 + index:
  - 150 writes with waddr 0..149 and wdata 0x1000..0x1095, each one cycle after its accept.
  - done=1 two cycles after the 150th accept.
- Random in_valid gaps (≈50% duty):
  - Write sequence identical to the full-rate case; we=0 on every cycle following a non-accept.
  - No address is skipped or duplicated.
- Kernel boundary:
  - Index 24 → waddr 24, index 25 → waddr 25, index 74 → 74, index 75 → 75.
  - The kernel counter reads 3 when waddr=75.
- start pulsed mid-LOAD after 40 words:
  - No effect; load completes at addresses 40..149.
  - in_valid during IDLE/DONE produces no writes.
- reset=0 after 60 accepted words:
  - The next cycle shows we=0, busy=0, in_ready=0.
  - A new start reloads from waddr 0.
- CONV2_K_WR_CHECKSUM_EN build, all 150 words = 0xFFFF:
  - checksum = 150×0xFFFF mod 2^24 = 0x95FF6A at done.
  - After start, checksum reads 0.
